mem_stage: RTL and testbench

Memory stage of the interrupt-capable pipelined CPU, directly downstream of the EXE/MEM pipeline register. It owns the word-organised data RAM, performs byte, half and word stores with byte enables, and performs sign- or zero-extended sub-word loads. It also flags misaligned accesses and carries the results through the MEM/WB pipeline register to write-back.

---
 rtl/mem_stage_if.sv | 36 +++
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: groups the EXE/MEM-side inputs and the MEM/WB-side outputs
// of the memory stage. The master drives the MEM-stage instruction fields;
// the slave (mem_stage) returns the exception flag and the write-back fields.
interface mem_stage_if;
  logic        mem_wreg;
  logic        mem_m2reg;
  logic        mem_wmem;
  logic [4:0]  mem_rn;
  logic [31:0] mem_alu;
  logic [31:0] mem_b;
  logic        mem_uns;
  logic        mem_half;
  logic        mem_byte;
  logic        mem_exc;
  logic        wb_wreg;
  logic        wb_m2reg;
  logic [4:0]  wb_rn;
  logic [31:0] wb_alu;
  logic [31:0] wb_mo;
  logic        wb_exc;
  logic [31:0] wb_badaddr;

  modport master (
    output mem_wreg, mem_m2reg, mem_wmem, mem_rn, mem_alu, mem_b,
           mem_uns, mem_half, mem_byte,
    input  mem_exc, wb_wreg, wb_m2reg, wb_rn, wb_alu, wb_mo, wb_exc,
           wb_badaddr
  );

  modport slave (
    input  mem_wreg, mem_m2reg, mem_wmem, mem_rn, mem_alu, mem_b,
           mem_uns, mem_half, mem_byte,
    output mem_exc, wb_wreg, wb_m2reg, wb_rn, wb_alu, wb_mo, wb_exc,
           wb_badaddr
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the pipelined CPU. Owns a word-organised data
// RAM with byte-enable stores, sign/zero-extending sub-word loads, and the
// MEM/WB pipeline register.
// Optional feature macro: MEM_ALIGN_EXC_EN -- when defined, misaligned
// half/word accesses raise mem_exc, suppress stores and squash wb_wreg.
module mem_stage #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  mem_stage_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // RAM is deliberately not reset; contents are undefined until written.
  logic [31:0] ram [DEPTH];

  logic [ADDR_WIDTH-1:0] widx;
  logic [1:0]            off;
  logic [31:0]           rword;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic                  st_en;
  logic [31:0]           ld_data;
  logic                  exc;

  // Upper address bits only alias the RAM; collected here so they read as
  // intentionally unused.
  logic unused_alu_hi;
  assign unused_alu_hi = ^bus.mem_alu[31:ADDR_WIDTH+2];

  function automatic logic [31:0] ext_byte(input logic [7:0] v, input logic uns);
    logic fill;
    fill = ~uns & v[7];
    return {{24{fill}}, v};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] v, input logic uns);
    logic fill;
    fill = ~uns & v[15];
    return {{16{fill}}, v};
  endfunction

  assign widx  = bus.mem_alu[ADDR_WIDTH+1:2];
  assign off   = bus.mem_alu[1:0];
  assign rword = ram[widx];

`ifdef MEM_ALIGN_EXC_EN
  logic misal;

  // Byte accesses are always aligned; halves need an even offset, words zero.
  always_comb begin
    misal = 1'b0;
    if (bus.mem_byte)
      misal = 1'b0;
    else if (bus.mem_half)
      misal = off[0];
    else
      misal = (off != 2'b00);
  end

  assign exc = misal & (bus.mem_wmem | bus.mem_m2reg);
`else
  assign exc = 1'b0;
`endif

  assign bus.mem_exc = exc;
  assign st_en       = bus.mem_wmem & ~exc;

  // Byte-lane enables and lane-replicated store data for the addressed size.
  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0;
    if (bus.mem_byte) begin
      be    = 4'b0001 << off;
      wdata = {4{bus.mem_b[7:0]}};
    end else if (bus.mem_half) begin
      be    = off[1] ? 4'b1100 : 4'b0011;
      wdata = {2{bus.mem_b[15:0]}};
    end else begin
      be    = 4'b1111;
      wdata = bus.mem_b;
    end
  end

  // Store commit; lanes outside the enable mask keep their old contents.
  always_ff @(posedge clk) begin
    if (clrn && st_en) begin
      if (be[0]) ram[widx][7:0]   <= wdata[7:0];
      if (be[1]) ram[widx][15:8]  <= wdata[15:8];
      if (be[2]) ram[widx][23:16] <= wdata[23:16];
      if (be[3]) ram[widx][31:24] <= wdata[31:24];
    end
  end

  // Lane select and extension of the combinational read word.
  always_comb begin
    ld_data = rword;
    if (bus.mem_byte) begin
      case (off)
        2'd0:    ld_data = ext_byte(rword[7:0],   bus.mem_uns);
        2'd1:    ld_data = ext_byte(rword[15:8],  bus.mem_uns);
        2'd2:    ld_data = ext_byte(rword[23:16], bus.mem_uns);
        default: ld_data = ext_byte(rword[31:24], bus.mem_uns);
      endcase
    end else if (bus.mem_half) begin
      ld_data = off[1] ? ext_half(rword[31:16], bus.mem_uns)
                       : ext_half(rword[15:0],  bus.mem_uns);
    end
  end

  // MEM/WB register: unconditional capture, cleared asynchronously by clrn.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bus.wb_wreg    <= 1'b0;
      bus.wb_m2reg   <= 1'b0;
      bus.wb_rn      <= 5'd0;
      bus.wb_alu     <= 32'h0;
      bus.wb_mo      <= 32'h0;
      bus.wb_exc     <= 1'b0;
      bus.wb_badaddr <= 32'h0;
    end else begin
      bus.wb_wreg    <= bus.mem_wreg & ~exc;
      bus.wb_m2reg   <= bus.mem_m2reg;
      bus.wb_rn      <= bus.mem_rn;
      bus.wb_alu     <= bus.mem_alu;
      bus.wb_mo      <= ld_data;
      bus.wb_exc     <= exc;
      bus.wb_badaddr <= exc ? bus.mem_alu : 32'h0;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bus();
  mem_stage #(.ADDR_WIDTH(8)) dut (.clk(clk), .clrn(clrn), .bus(bus));

`ifdef MEM_ALIGN_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  // Reference memory: a flat byte array over the 1 KiB aliased byte space.
  logic [7:0] mem   [1024];
  bit         known [1024];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit wreg, input bit m2reg, input bit wmem, input logic [4:0] rn,
                       input logic [31:0] alu, input logic [31:0] b,
                       input bit uns, input bit half, input bit byt);
    bus.mem_wreg  = wreg;
    bus.mem_m2reg = m2reg;
    bus.mem_wmem  = wmem;
    bus.mem_rn    = rn;
    bus.mem_alu   = alu;
    bus.mem_b     = b;
    bus.mem_uns   = uns;
    bus.mem_half  = half;
    bus.mem_byte  = byt;
  endtask

  task automatic check_wb_zero(input string tag);
    check({tag, ".wreg"},  32'(bus.wb_wreg),  32'h0);
    check({tag, ".m2reg"}, 32'(bus.wb_m2reg), 32'h0);
    check({tag, ".rn"},    32'(bus.wb_rn),    32'h0);
    check({tag, ".alu"},   bus.wb_alu,        32'h0);
    check({tag, ".mo"},    bus.wb_mo,         32'h0);
    check({tag, ".exc"},   32'(bus.wb_exc),   32'h0);
    check({tag, ".bad"},   bus.wb_badaddr,    32'h0);
  endtask

  // One MEM-stage instruction: called just after a rising edge, returns just
  // after the edge that captured it into MEM/WB.
  task automatic op(input string tag, input bit wreg, input bit m2reg, input bit wmem,
                    input logic [4:0] rn, input logic [31:0] alu, input logic [31:0] b,
                    input bit uns, input bit half, input bit byt);
    int a, base, n;
    bit mis, exc, ok;
    logic [31:0] ld;
    drive(wreg, m2reg, wmem, rn, alu, b, uns, half, byt);
    a    = int'(alu[9:0]);
    n    = byt ? 1 : (half ? 2 : 4);
    base = (n == 1) ? a : ((n == 2) ? (a & ~1) : (a & ~3));
    mis  = (n == 2 && alu[0]) || (n == 4 && alu[1:0] != 2'b00);
    exc  = EXC_EN && mis && (wmem || m2reg);
    ld = 32'h0;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      ld = ld | ({24'h0, mem[base + i]} << (8 * i));
      ok = ok && known[base + i];
    end
    if (n < 4 && !uns && ld[8 * n - 1])
      ld = ld | (32'hFFFF_FFFF << (8 * n));
    #1;
    check({tag, ".mem_exc"}, 32'(bus.mem_exc), 32'(exc));
    @(posedge clk);
    #1;
    check({tag, ".wb_wreg"},  32'(bus.wb_wreg),  32'(wreg && !exc));
    check({tag, ".wb_m2reg"}, 32'(bus.wb_m2reg), 32'(m2reg));
    check({tag, ".wb_rn"},    32'(bus.wb_rn),    32'(rn));
    check({tag, ".wb_alu"},   bus.wb_alu,        alu);
    check({tag, ".wb_exc"},   32'(bus.wb_exc),   32'(exc));
    check({tag, ".wb_bad"},   bus.wb_badaddr,    exc ? alu : 32'h0);
    if (m2reg && ok)
      check({tag, ".wb_mo"}, bus.wb_mo, ld);
    if (wmem && !exc) begin
      for (int i = 0; i < n; i++) begin
        mem[base + i]   = 8'(b >> (8 * i));
        known[base + i] = 1'b1;
      end
    end
  endtask

  initial begin
    int r, sz;
    logic [31:0] ra;
    for (int i = 0; i < 1024; i++) begin
      mem[i]   = 8'h0;
      known[i] = 1'b0;
    end
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_wb_zero("init_reset");

    // Release reset with a store presented in the same cycle.
    clrn = 1'b1;
    op("st_w10", 0, 0, 1, 5'd0, 32'h10, 32'h5555_AAAA, 0, 0, 0);
    op("pass", 1, 0, 0, 5'd7, 32'h1234, 32'h0, 0, 0, 0);
    check("pass_alu", bus.wb_alu, 32'h1234);
    check("pass_rn", 32'(bus.wb_rn), 32'd7);
    check("pass_wreg", 32'(bus.wb_wreg), 32'd1);

    // Reset mid-store: outputs clear asynchronously, the store is dropped.
    drive(1, 0, 1, 5'd3, 32'h10, 32'h1111_1111, 0, 0, 0);
    #1;
    clrn = 1'b0;
    #1;
    check_wb_zero("async_clr");
    @(posedge clk);
    #1;
    check_wb_zero("held_clr");
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 0);
    clrn = 1'b1;
    op("ld_w10", 1, 1, 0, 5'd2, 32'h10, 32'h0, 0, 0, 0);
    check("rst_keep_w4", bus.wb_mo, 32'h5555_AAAA);

    // Sub-word stores merged into a word.
    op("st_w04", 0, 0, 1, 5'd0, 32'h04, 32'hAABB_CCDD, 0, 0, 0);
    op("st_b05", 0, 0, 1, 5'd0, 32'h05, 32'h0000_0012, 0, 0, 1);
    op("st_h06", 0, 0, 1, 5'd0, 32'h06, 32'h0000_3344, 0, 1, 0);
    op("ld_w04", 1, 1, 0, 5'd1, 32'h04, 32'h0, 0, 0, 0);
    check("merge_w04", bus.wb_mo, 32'h3344_12DD);

    // Load extension.
    op("st_w08", 0, 0, 1, 5'd0, 32'h08, 32'h80F0_7F01, 0, 0, 0);
    op("lb_0b", 1, 1, 0, 5'd4, 32'h0B, 32'h0, 0, 0, 1);
    check("lb_signed", bus.wb_mo, 32'hFFFF_FF80);
    op("lbu_0b", 1, 1, 0, 5'd4, 32'h0B, 32'h0, 1, 0, 1);
    check("lbu", bus.wb_mo, 32'h0000_0080);
    op("lh_08", 1, 1, 0, 5'd4, 32'h08, 32'h0, 0, 1, 0);
    check("lh_lo", bus.wb_mo, 32'h0000_7F01);
    op("lh_0a", 1, 1, 0, 5'd4, 32'h0A, 32'h0, 0, 1, 0);
    check("lh_hi", bus.wb_mo, 32'hFFFF_80F0);

    // Back-to-back store then load.
    op("st_w20", 0, 0, 1, 5'd0, 32'h20, 32'hDEAD_BEEF, 0, 0, 0);
    op("ld_w20", 1, 1, 0, 5'd9, 32'h20, 32'h0, 0, 0, 0);
    check("b2b", bus.wb_mo, 32'hDEAD_BEEF);

    // Misaligned accesses.
    op("st_w0c", 0, 0, 1, 5'd0, 32'h0C, 32'h0102_0304, 0, 0, 0);
    op("sh_0d", 0, 0, 1, 5'd0, 32'h0D, 32'h0000_FFFF, 0, 1, 0);
`ifdef MEM_ALIGN_EXC_EN
    check("mis_wb_exc", 32'(bus.wb_exc), 32'd1);
    check("mis_bad", bus.wb_badaddr, 32'h0000_000D);
`endif
    op("ld_w0c", 1, 1, 0, 5'd5, 32'h0C, 32'h0, 0, 0, 0);
`ifdef MEM_ALIGN_EXC_EN
    check("mis_keep", bus.wb_mo, 32'h0102_0304);
`endif
    op("lw_02", 1, 1, 0, 5'd6, 32'h02, 32'h0, 0, 0, 0);
`ifdef MEM_ALIGN_EXC_EN
    check("mis_ld_wreg", 32'(bus.wb_wreg), 32'd0);
    check("mis_ld_exc", 32'(bus.wb_exc), 32'd1);
`endif

    // Address wrap.
    op("st_400", 0, 0, 1, 5'd0, 32'h400, 32'hCAFE_F00D, 0, 0, 0);
    op("ld_000", 1, 1, 0, 5'd8, 32'h000, 32'h0, 0, 0, 0);
    check("wrap", bus.wb_mo, 32'hCAFE_F00D);

    // Randomized mix against the byte-array model.
    for (int k = 0; k < 400; k++) begin
      r  = $urandom_range(0, 9);
      sz = $urandom_range(0, 2);
      ra = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      op("rnd", 1'($urandom), (r >= 4 && r <= 8), (r <= 3 || r == 8),
         5'($urandom), ra, $urandom, 1'($urandom), (sz == 1), (sz == 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
